// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 5;
  localparam int MUL_ITER  = 32;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    logic gg;
    logic gp;

    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign gg     = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp     = p[B+3] & p[B+2] & p[B+1] & p[B];
    assign c[B+4] = gg | (gp & c[B]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/mul_seq32.sv
// Multi-cycle unsigned 32x32->64 shift-and-add multiplier around one cla32.
// Optional macro MUL_SEQ_EARLY_EXIT_EN: finish as soon as no multiplier ones remain.
module mul_seq32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  mul_state_t state_q, state_d;

  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] step;
  logic               last_iter;
  logic               exit_early;
  logic [2*WIDTH-1:0] z_early;

  assign add_b     = p_q[0] ? m_q : '0;
  assign step      = {add_cout, add_sum, p_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == LAST_CNT);

  cla32 u_add (
    .a    (p_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .ci   (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam logic [CNT_W:0] WIDTH_C = (CNT_W+1)'(WIDTH);

  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CNT_W:0]   shamt;

  // P still holds the product shifted left by (WIDTH - count); undo that in one step.
  assign shamt      = WIDTH_C - {1'b0, cnt_q};
  assign z_early    = p_q >> shamt;
  assign exit_early = (mq_q == '0);

  always_comb begin
    mq_d = mq_q;
    if (state_q == IDLE && start) begin
      mq_d = b;
    end else if (state_q == RUN) begin
      mq_d = mq_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_q <= '0;
    end else begin
      mq_q <= mq_d;
    end
  end
`else
  assign z_early    = '0;
  assign exit_early = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (exit_early || last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    z_d    = z_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = a;
          p_d   = {{WIDTH{1'b0}}, b};
          cnt_d = '0;
        end
      end
      RUN: begin
        if (exit_early) begin
          z_d    = z_early;
          done_d = 1'b1;
        end else begin
          p_d   = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            z_d    = step;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      z_q    <= '0;
      done_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
      done_q <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: tb/tb_mul_seq32.sv
// Directed self-checking bench for mul_seq32 (default and MUL_SEQ_EARLY_EXIT_EN builds).
module tb_mul_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] z;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mul_seq32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  // Cycle (1 = cycle after the start edge) in which done is expected.
  function automatic int exp_lat(input logic [31:0] bb);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) if (bb[i]) k = i + 1;
    return (k + 2 < 33) ? k + 2 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one start and follow the operation until done (bounded), plus one cycle after.
  task automatic run_mul(input logic [31:0] aa, input logic [31:0] bb,
                         output logic [63:0] zz, output int lat, output int bcyc,
                         output int dcnt);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 1;
    bcyc = busy ? 1 : 0;
    dcnt = done ? 1 : 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
      if (done) dcnt++;
    end
    zz = z;
    @(posedge clk); #1;
    if (done) dcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (z !== 64'd0) $display("FAIL reset_z: got %h want 0", z); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] zz;
    int lat, bcyc, dcnt;
    run_mul(32'd7, 32'd6, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'd42) $display("FAIL basic_z: got %0d want 42", zz); else passes++;
    checks++; if (lat !== exp_lat(32'd6)) $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(32'd6)); else passes++;
    checks++; if (bcyc !== exp_lat(32'd6)) $display("FAIL basic_busy_cycles: got %0d want %0d", bcyc, exp_lat(32'd6)); else passes++;
    checks++; if (dcnt !== 1) $display("FAIL basic_done_pulses: got %0d want 1", dcnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle_after: busy %b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] zz;
    int lat, bcyc, dcnt, seen;
    @(negedge clk);
    a = 32'd3; b = 32'h8000_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL midrun_reset_done: got %b want 0", done); else passes++;
    checks++; if (z !== 64'd0) $display("FAIL midrun_reset_z: got %h want 0", z); else passes++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrun_no_resume: active cycles %0d want 0", seen); else passes++;
    run_mul(32'd3, 32'h8000_0001, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'h0000_0001_8000_0003) $display("FAIL after_reset_z: got %h want 0000000180000003", zz); else passes++;
    checks++; if (lat !== 33) $display("FAIL after_reset_latency: got %0d want 33", lat); else passes++;
  endtask

  task automatic test_max_carry();
    logic [63:0] zz;
    int lat, bcyc, dcnt;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'hFFFF_FFFE_0000_0001) $display("FAIL maxcarry_z: got %h want fffffffe00000001", zz); else passes++;
    checks++; if (dcnt !== 1) $display("FAIL maxcarry_done_pulses: got %0d want 1", dcnt); else passes++;
    checks++; if (lat !== 33) $display("FAIL maxcarry_latency: got %0d want 33", lat); else passes++;
  endtask

  task automatic test_ignored_start();
    int lat, dcnt;
    @(negedge clk);
    a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; dcnt = 0;
    while (!done && lat < 60) begin
      if (lat == 2 || lat == 3) begin
        a = 32'd9; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) dcnt++;
    end
    start = 1'b0;
    checks++; if (z !== 64'd15) $display("FAIL ignored_start_z: got %0d want 15", z); else passes++;
    checks++; if (lat !== exp_lat(32'd5)) $display("FAIL ignored_start_latency: got %0d want %0d", lat, exp_lat(32'd5)); else passes++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    checks++; if (dcnt !== 1) $display("FAIL ignored_start_done_pulses: got %0d want 1", dcnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ignored_start_idle: busy %b want 0", busy); else passes++;
  endtask

  task automatic test_zero_identity();
    logic [63:0] zz;
    int lat, bcyc, dcnt;
    run_mul(32'h1234_5678, 32'd1, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'h0000_0000_1234_5678) $display("FAIL identity_z: got %h want 0000000012345678", zz); else passes++;
    checks++; if (lat !== exp_lat(32'd1)) $display("FAIL identity_latency: got %0d want %0d", lat, exp_lat(32'd1)); else passes++;
    run_mul(32'd0, 32'hDEAD_BEEF, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'd0) $display("FAIL zero_z: got %h want 0", zz); else passes++;
    checks++; if (lat !== 33) $display("FAIL zero_latency: got %0d want 33", lat); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] zz;
    int lat, bcyc, dcnt;
    @(negedge clk);
    a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (z !== 64'd1000000) $display("FAIL b2b_first_z: got %0d want 1000000", z); else passes++;
    // Start held from the done cycle: ignored in DONE, accepted one edge later.
    a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done: busy %b want 0", busy); else passes++;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy %b want 1", busy); else passes++;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (z !== 64'h0000_0001_0000_0000) $display("FAIL b2b_second_z: got %h want 0000000100000000", z); else passes++;
    checks++; if (lat !== exp_lat(32'h0001_0000)) $display("FAIL b2b_second_latency: got %0d want %0d", lat, exp_lat(32'h0001_0000)); else passes++;
    @(posedge clk); #1;
    run_mul(32'd2, 32'd21, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'd42) $display("FAIL b2b_third_z: got %0d want 42", zz); else passes++;
  endtask

`ifdef MUL_SEQ_EARLY_EXIT_EN
  task automatic test_early_exit();
    logic [63:0] zz;
    int lat, bcyc, dcnt;
    run_mul(32'd5, 32'd3, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'd15) $display("FAIL early_z: got %0d want 15", zz); else passes++;
    checks++; if (lat !== 4) $display("FAIL early_latency: got %0d want 4", lat); else passes++;
    run_mul(32'hCAFE_F00D, 32'd0, zz, lat, bcyc, dcnt);
    checks++; if (zz !== 64'd0) $display("FAIL early_b0_z: got %h want 0", zz); else passes++;
    checks++; if (lat !== 2) $display("FAIL early_b0_latency: got %0d want 2", lat); else passes++;
    checks++; if (dcnt !== 1) $display("FAIL early_b0_done_pulses: got %0d want 1", dcnt); else passes++;
  endtask
`endif

  task automatic test_random();
    logic [63:0] zz;
    logic [31:0] ra, rb;
    int lat, bcyc, dcnt, n, bad_z, bad_lat;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    n = 1000;
`else
    n = 40;
`endif
    bad_z = 0; bad_lat = 0;
    for (int i = 0; i < n; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_mul(ra, rb, zz, lat, bcyc, dcnt);
      if (zz !== 64'(ra) * 64'(rb)) begin
        if (bad_z == 0) $display("FAIL random_z: a=%h b=%h got %h want %h", ra, rb, zz, 64'(ra) * 64'(rb));
        bad_z++;
      end
      if (lat !== exp_lat(rb)) begin
        if (bad_lat == 0) $display("FAIL random_latency: b=%h got %0d want %0d", rb, lat, exp_lat(rb));
        bad_lat++;
      end
    end
    checks++; if (bad_z !== 0) $display("FAIL random_products: %0d wrong want 0", bad_z); else passes++;
    checks++; if (bad_lat !== 0) $display("FAIL random_latencies: %0d wrong want 0", bad_lat); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_max_carry();
    test_ignored_start();
    test_zero_identity();
    test_back_to_back();
`ifdef MUL_SEQ_EARLY_EXIT_EN
    test_early_exit();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
